counter_bcd_chain: RTL and testbench

//   Parametrised multi-digit up/down counter; successor to the single mod-10 digit counter.

---
 rtl/counter_bcd_chain.sv | 121 ++++++++++++
 tb/tb_counter_bcd_chain.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bcd_chain.sv
// Multi-digit mixed-radix up/down counter with synchronous load and
// wrap-or-saturate behaviour at the count limits.
//
// Ports:
//   clock   rising-edge clock
//   clear   asynchronous active-high reset (digits=0, done=0)
//   loadn   synchronous load, active low (beats counting)
//   en      count enable
//   up      direction, 1 = up, 0 = down
//   data    load value, digit0 in [3:0], fields clamped to MOD_i-1
//   digits  current count (registered)
//   zero    all digits 0 (combinational)
//   tc      terminal count for the current direction (combinational)
//   done    one-cycle pulse after a down count reaches zero (registered)
module counter_bcd_chain #(
    parameter int unsigned DIGITS = 4,
    parameter logic [31:0] MODULI = 32'h0000_6A6A,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  loadn,
    input  logic                  en,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  zero,
    output logic                  tc,
    output logic                  done
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] digits_q;
    logic [W-1:0] count_nxt;
    logic [W-1:0] load_nxt;
    logic [W-1:0] digits_nxt;
    logic         done_q;
    logic         done_nxt;
    logic         all_zero;
    logic         all_max;
    logic         ripple;

    // Limit detection over the whole chain.
    always_comb begin
        all_zero = 1'b1;
        all_max  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] != 4'd0)
                all_zero = 1'b0;
            if (digits_q[4*i +: 4] != (MODULI[4*i +: 4] - 4'd1))
                all_max = 1'b0;
        end
    end

    // Ripple carry/borrow: a digit steps only while every lower digit wrapped.
    always_comb begin
        count_nxt = digits_q;
        ripple    = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                if (up) begin
                    if (digits_q[4*i +: 4] == (MODULI[4*i +: 4] - 4'd1)) begin
                        count_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        count_nxt[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (digits_q[4*i +: 4] == 4'd0) begin
                        count_nxt[4*i +: 4] = MODULI[4*i +: 4] - 4'd1;
                    end else begin
                        count_nxt[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
    end

    // Load value with out-of-range fields clamped to the digit maximum.
    always_comb begin
        load_nxt = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (data[4*i +: 4] >= MODULI[4*i +: 4])
                load_nxt[4*i +: 4] = MODULI[4*i +: 4] - 4'd1;
            else
                load_nxt[4*i +: 4] = data[4*i +: 4];
        end
    end

    // Next state: load > count > hold; done only on a counted arrival at zero.
    always_comb begin
        digits_nxt = digits_q;
        done_nxt   = 1'b0;
        if (!loadn) begin
            digits_nxt = load_nxt;
        end else if (en) begin
            if (WRAP || !(up ? all_max : all_zero)) begin
                digits_nxt = count_nxt;
                done_nxt   = !up && !all_zero && (count_nxt == '0);
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            digits_q <= digits_nxt;
            done_q   <= done_nxt;
        end
    end

    assign digits = digits_q;
    assign done   = done_q;
    assign zero   = all_zero;
    assign tc     = en & ((~up & all_zero) | (up & all_max));

endmodule

// File: tb/tb_counter_bcd_chain.sv
module tb_counter_bcd_chain;

    localparam int MODS[4] = '{10, 6, 10, 6};
    localparam int TOTAL   = 3600;

    logic        clock = 1'b0;
    logic        clear;
    logic        loadn;
    logic        en;
    logic        up;
    logic [15:0] data;
    logic [15:0] digits_w, digits_s;
    logic        zero_w, zero_s, tc_w, tc_s, done_w, done_s;

    int n_checks = 0;
    int n_fail   = 0;
    int val_w    = 0;
    int val_s    = 0;
    bit dn_w     = 1'b0;
    bit dn_s     = 1'b0;

    always #5 clock = ~clock;

    counter_bcd_chain #(.DIGITS(4), .MODULI(32'h0000_6A6A), .WRAP(1'b1)) dut_wrap (
        .clock(clock), .clear(clear), .loadn(loadn), .en(en), .up(up), .data(data),
        .digits(digits_w), .zero(zero_w), .tc(tc_w), .done(done_w));

    counter_bcd_chain #(.DIGITS(4), .MODULI(32'h0000_6A6A), .WRAP(1'b0)) dut_sat (
        .clock(clock), .clear(clear), .loadn(loadn), .en(en), .up(up), .data(data),
        .digits(digits_s), .zero(zero_s), .tc(tc_s), .done(done_s));

    typedef struct {
        bit          loadn;
        bit          en;
        bit          up;
        logic [15:0] data;
        int          reps;
        logic [15:0] exp_digits;
        bit          exp_done;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model works on the counter value as a plain integer in 0..TOTAL-1.
    function automatic logic [15:0] to_digits(input int v);
        logic [15:0] d;
        int          r;
        d = '0;
        r = v;
        for (int i = 0; i < 4; i++) begin
            d[4*i +: 4] = 4'(r % MODS[i]);
            r = r / MODS[i];
        end
        return d;
    endfunction

    function automatic int load_val(input logic [15:0] dat);
        int v;
        int w;
        int f;
        v = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            f = int'(dat[4*i +: 4]);
            if (f >= MODS[i]) f = MODS[i] - 1;
            v += f * w;
            w *= MODS[i];
        end
        return v;
    endfunction

    function automatic int step_val(input int v, input bit wrap, input bit ld_n, input bit e,
                                    input bit u, input logic [15:0] dat, output bit dn);
        dn = 1'b0;
        if (!ld_n) return load_val(dat);
        if (!e) return v;
        if (u) begin
            if (v == TOTAL - 1) return wrap ? 0 : v;
            return v + 1;
        end
        if (v == 0) return wrap ? TOTAL - 1 : 0;
        if (v == 1) dn = 1'b1;
        return v - 1;
    endfunction

    function automatic bit exp_tc(input int v, input bit e, input bit u);
        return e && ((!u && v == 0) || (u && v == TOTAL - 1));
    endfunction

    task automatic check_state();
        check("digits_wrap", 32'(digits_w), 32'(to_digits(val_w)));
        check("digits_sat",  32'(digits_s), 32'(to_digits(val_s)));
        check("zero_wrap",   32'(zero_w),   32'(val_w == 0));
        check("zero_sat",    32'(zero_s),   32'(val_s == 0));
        check("done_wrap",   32'(done_w),   32'(dn_w));
        check("done_sat",    32'(done_s),   32'(dn_s));
    endtask

    // Drive one cycle of inputs, check tc before the edge and state after it.
    task automatic cycle(input bit ld_n, input bit e, input bit u, input logic [15:0] dat);
        loadn = ld_n;
        en    = e;
        up    = u;
        data  = dat;
        #1;
        check("tc_wrap", 32'(tc_w), 32'(exp_tc(val_w, e, u)));
        check("tc_sat",  32'(tc_s), 32'(exp_tc(val_s, e, u)));
        @(posedge clock);
        val_w = step_val(val_w, 1'b1, ld_n, e, u, dat, dn_w);
        val_s = step_val(val_s, 1'b0, ld_n, e, u, dat, dn_s);
        #1;
        check_state();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        val_w = 0;
        val_s = 0;
        dn_w  = 1'b0;
        dn_s  = 1'b0;
        check("clear_digits", 32'(digits_w), 32'h0);
        check("clear_zero",   32'(zero_w),   32'h1);
        check("clear_done",   32'(done_w),   32'h0);
        check_state();
        clear = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        clear = 1'b1;
        loadn = 1'b1;
        en    = 1'b0;
        up    = 1'b0;
        data  = '0;
        #12;
        check("reset_digits", 32'(digits_w), 32'h0);
        check("reset_zero",   32'(zero_w),   32'h1);
        check("reset_done",   32'(done_w),   32'h0);
        check_state();
        clear = 1'b0;

        // Directed table, expectations for the wrapping instance.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0959, 1, 16'h0959, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'h0958, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 9, 16'h0949, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0100, 1, 16'h0100, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'h0059, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0059, 1, 16'h0059, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1, 16'h0100, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0999, 1, 16'h0959, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 1, 16'h0001, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'h0000, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'h5959, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1, 16'h0000, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 1, 16'h5959, 1'b0};

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++)
                cycle(vecs[k].loadn, vecs[k].en, vecs[k].up, vecs[k].data);
            check("vec_digits", 32'(digits_w), 32'(vecs[k].exp_digits));
            check("vec_done",   32'(done_w),   32'(vecs[k].exp_done));
        end

        // Clear mid-count at 0x0347, no clock edge needed.
        cycle(1'b0, 1'b0, 1'b1, 16'h0340);
        for (int r = 0; r < 7; r++) cycle(1'b1, 1'b1, 1'b1, 16'h0000);
        check("pre_clear", 32'(digits_w), 32'h0347);
        pulse_clear();

        // Saturating instance: 0002 down to zero, single done pulse, then hold.
        cycle(1'b0, 1'b0, 1'b0, 16'h0002);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        check("sat_one", 32'(digits_s), 32'h0001);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        check("sat_zero",      32'(digits_s), 32'h0000);
        check("sat_done_high", 32'(done_s),   32'h1);
        loadn = 1'b1; en = 1'b1; up = 1'b0;
        #1;
        check("sat_tc_hold", 32'(tc_s), 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        check("sat_hold",     32'(digits_s), 32'h0000);
        check("sat_done_low", 32'(done_s),   32'h0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        check("sat_hold2", 32'(digits_s), 32'h0000);

        // Wrapping instance: 0000 down wraps to 5959, tc before the edge.
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        loadn = 1'b1; en = 1'b1; up = 1'b0;
        #1;
        check("wrap_tc_down", 32'(tc_w), 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        check("wrap_down", 32'(digits_w), 32'h5959);
        cycle(1'b1, 1'b1, 1'b1, 16'h0000);
        check("wrap_up", 32'(digits_w), 32'h0000);

        // Randomized traffic against the integer model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0:       rd = 16'($urandom());
                1:       rd = 16'h0000;
                2:       rd = 16'h0001;
                3:       rd = 16'h5959;
                default: rd = 16'h5958;
            endcase
            if ($urandom_range(0, 199) == 0)
                pulse_clear();
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
